// File: rtl/apb_pkg.sv
// Shared APB definitions for the slave slice: bus widths, FSM encoding and
// the default memory base address.
package apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    localparam logic [APB_AW-1:0] APB_DEF_BASE = 32'h0000_A000;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_slv_regfile.sv
// DEPTH x 32-bit word store: synchronous clear, one write port and one
// combinational read port sharing the same index.
module apb_slv_regfile
    import apb_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic              Pclk,
    input  logic              Prst,
    input  logic              we_i,
    input  logic [IW-1:0]     idx_i,
    input  logic [APB_DW-1:0] wdata_i,
    output logic [APB_DW-1:0] rdata_o
);

    logic [APB_DW-1:0] mem_q [DEPTH];

    // Word storage: reset clears every entry, otherwise one optional write.
    always_ff @(posedge Pclk) begin
        if (Prst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {APB_DW{1'b0}};
            end
        end else if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/apb_mem_slave.sv
// APB word-memory slave with programmable wait states. Define APB_SLV_ERR_EN
// to report out-of-range or misaligned accesses on P_slverr.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter logic [APB_AW-1:0] BASE_ADDR   = APB_DEF_BASE,
    parameter int                DEPTH       = 16,
    parameter int                WAIT_STATES = 1
) (
    input  logic              Pclk,
    input  logic              Prst,
    input  logic [APB_AW-1:0] Paddr,
    input  logic              PSELx,
    input  logic              P_en,
    input  logic              P_WR,
    input  logic [APB_DW-1:0] PWdata,
    output logic [APB_DW-1:0] PRdata,
    output logic              P_ready,
    output logic              P_slverr
);

    localparam int                IW   = $clog2(DEPTH);
    localparam logic [APB_AW-1:0] SPAN = APB_AW'(DEPTH * 4);
    localparam logic [3:0]        WS   = 4'(WAIT_STATES);

    apb_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [APB_AW-1:0] off_s;
    logic              hit_s;
    logic [IW-1:0]     idx_s;
    logic              complete_s;
    logic              done_s;
    logic              we_s;
    logic [APB_DW-1:0] rdata_s;

    assign off_s = Paddr - BASE_ADDR;
    assign hit_s = (Paddr >= BASE_ADDR) && (off_s < SPAN) && (Paddr[1:0] == 2'b00);
    assign idx_s = off_s[IW+1:2];

    // A reset on the completion edge wins: nothing commits, nothing is reported.
    assign done_s = complete_s && !Prst;
    assign we_s   = done_s && P_WR && hit_s;

    apb_slv_regfile #(.DEPTH(DEPTH)) u_regfile (
        .Pclk    (Pclk),
        .Prst    (Prst),
        .we_i    (we_s),
        .idx_i   (idx_s),
        .wdata_i (PWdata),
        .rdata_o (rdata_s)
    );

    // State and wait-counter registers.
    always_ff @(posedge Pclk) begin
        if (Prst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Transfer sequencing: SETUP loads the counter, ACCESS counts down to completion.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        complete_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSELx && !P_en) begin
                    state_d = ACCESS;
                    cnt_d   = WS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (!PSELx) begin
                    state_d = IDLE;
                end else if (!P_en) begin
                    cnt_d = WS;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    complete_s = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response outputs are only non-zero during the completion cycle.
    always_comb begin
        P_ready  = 1'b0;
        PRdata   = {APB_DW{1'b0}};
        P_slverr = 1'b0;
        if (done_s) begin
            P_ready = 1'b1;
            if (!P_WR && hit_s) begin
                PRdata = rdata_s;
            end else begin
                PRdata = {APB_DW{1'b0}};
            end
`ifdef APB_SLV_ERR_EN
            P_slverr = ~hit_s;
`else
            P_slverr = 1'b0;
`endif
        end else begin
            P_ready  = 1'b0;
            PRdata   = {APB_DW{1'b0}};
            P_slverr = 1'b0;
        end
    end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- APB slave that sits directly downstream of the team's APB master and consumes its Paddr/PSELx/P_en/P_WR/PWdata transfers.
- Provides a word-addressed register memory of DEPTH 32-bit words, mapped at BASE_ADDR.
- Inserts a programmable number of wait states before asserting P_ready.
- Returns read data on PRdata and optionally flags bad accesses on P_slverr.

Parameters:
- BASE_ADDR, 32'h0000_A000: byte address of word 0.
- DEPTH, 16: number of 32-bit words; must be a power of two and at least 2.
- WAIT_STATES, 1: ACCESS cycles with P_ready low before completion; range 0..15.

Ports:
- Pclk  in  1  clock; all state updates on its rising edge.
- Prst  in  1  reset, synchronous, active-high.
- Paddr  in  32  byte address from the master.
- PSELx  in  1  slave select.
- P_en  in  1  enable (ACCESS phase).
- P_WR  in  1  1 = write, 0 = read.
- PWdata  in  32  write data.
- PRdata  out  32  read data.
- P_ready  out  1  transfer completion.
- P_slverr  out  1  error response; valid only while P_ready=1.

Behaviour:
- Reset (Prst=1 at a Pclk edge):
  - state goes to IDLE; wait counter goes to 0; every memory word goes to 32'h0.
  - P_ready=0, PRdata=32'h0, P_slverr=0 until the first completion after reset.
- Decode (combinational):
  - off = Paddr - BASE_ADDR.
  - hit = (Paddr >= BASE_ADDR) && (off < DEPTH*4) && (Paddr[1:0] == 2'b00).
  - idx = off[$clog2(DEPTH)+1:2].
- State machine:
  - IDLE: if PSELx=1 and P_en=0 (SETUP seen), go to ACCESS and load cnt = WAIT_STATES. Any other input combination stays in IDLE.
  - ACCESS, PSELx=1 and P_en=1 and cnt!=0: decrement cnt; P_ready=0; stay in ACCESS.
  - ACCESS, PSELx=1 and P_en=1 and cnt==0: completion cycle.
    - P_ready=1 combinationally.
    - Read: PRdata = mem[idx] combinationally.
    - Write with hit=1: mem[idx] <= PWdata at the closing edge.
    - Next state is IDLE.
  - ACCESS, PSELx=0: master abort; go to IDLE with no memory update.
  - ACCESS, PSELx=1 and P_en=0: treat as a new SETUP; reload cnt and stay in ACCESS.
- Latency: SETUP plus (WAIT_STATES+1) ACCESS cycles. WAIT_STATES=0 gives the minimum 2-cycle APB transfer.
- Outputs outside the completion cycle: P_ready=0, PRdata=32'h0, P_slverr=0.
- Back-to-back: a SETUP in the cycle right after completion is accepted, because the FSM is already in IDLE.
- Address/control stability: Paddr, P_WR and PWdata are sampled live every cycle; the master guarantees they are stable through ACCESS.
- Read with hit=0 returns 32'h0. Write with hit=0 changes no memory word.
- Reset in mid-transfer has priority over a completion on the same edge: no write commits and the state goes to IDLE.
- The counter never underflows; cnt is 4 bits wide.

Optional Feature:
- Macro APB_SLV_ERR_EN.
- Defined: on the completion cycle P_slverr = ~hit, which covers out-of-range and misaligned addresses. Bad writes are still discarded and bad reads still return 0.
- Undefined: P_slverr is tied to 0 and the decode only discards or zeroes bad accesses.

Decomposition:
- Shared package apb_pkg:
  - APB_AW=32 and APB_DW=32.
  - State enum {IDLE=1'b0, ACCESS=1'b1}.
  - Default base address constant 32'hA000.
- One sub-module apb_slv_regfile:
  - DEPTH x 32 array with synchronous clear on Prst, one write port (we, idx, wdata) and one combinational read port.
- The FSM, counter and decode stay in apb_mem_slave.

Test Plan:
- Write 32'h0000_0005 to 0xA000 with WAIT_STATES=1, then read 0xA000 -> P_ready high on the 2nd ACCESS cycle each time; the read returns PRdata=32'h5 and P_slverr=0.
- Drive Prst=1 after writing 0xA004=32'hDEAD_BEEF, then read 0xA004 -> PRdata=32'h0 and P_ready=0 during reset.
- Read 0xA000 (value 5) and in the very next cycle start a write of 32'h6 to 0xA000, i.e. the master's increment loop -> both complete with no idle gap; a subsequent read returns 32'h6.
- With APB_SLV_ERR_EN, write to 0xA040 (DEPTH=16) and read 0xA002 -> P_slverr=1 on both completions, memory unchanged, read data 32'h0. Without the macro -> P_slverr=0 throughout.
- Drop PSELx in the 1st ACCESS cycle of a write of 32'h1234 to 0xA008 -> FSM returns to IDLE and a following read of 0xA008 returns 32'h0.
- Assert Prst on the completion edge of a write of 32'hAAAA to 0xA00C -> no commit; a read after reset returns 32'h0.
